// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// =============================================================================
// time_set_ctrl_if
// Key, current-time, edited-time and load handshake signals of time_set_ctrl.
// Revision: 1.0
// =============================================================================
interface time_set_ctrl_if;
  logic       keyModeN;
  logic       keyIncN;
  logic [4:0] curHour;
  logic [5:0] curMin;
  logic [5:0] curSec;
  logic       loadAck;
  logic [4:0] setHour;
  logic [5:0] setMin;
  logic [5:0] setSec;
  logic       loadReq;
  logic       editing;
  logic [1:0] editField;

  modport master (
    output keyModeN, keyIncN, curHour, curMin, curSec, loadAck,
    input  setHour, setMin, setSec, loadReq, editing, editField
  );

  modport slave (
    input  keyModeN, keyIncN, curHour, curMin, curSec, loadAck,
    output setHour, setMin, setSec, loadReq, editing, editField
  );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// =============================================================================
// time_set_ctrl
// Debounced two-key hh:mm:ss editor with auto-repeat, edit timeout and
// req/ack load into the clock counter.
// Revision: 1.0
// =============================================================================
module time_set_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int TIMEOUT         = 500_000_000
) (
  input  logic           clk,
  input  logic           reset,
  time_set_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] c_deb_last = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] c_dly_last = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] c_per_last = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] c_to_last  = TW'(TIMEOUT - 1);

  if (DEBOUNCE_CYCLES < 2 || CLK_HZ < 1) begin : g_param_check
    $error("time_set_ctrl: DEBOUNCE_CYCLES must be >= 2 and CLK_HZ positive");
  end

  // Bit 0 is the mode key, bit 1 the increment key.
  logic [1:0] w_raw;
  logic [1:0] w_deb;
  logic [1:0] w_press;
  assign w_raw = {bus.keyIncN, bus.keyModeN};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]    r_sync;
    logic [DW-1:0] r_cnt;
    logic          r_deb;
    logic          r_press;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync  <= 2'b11;
        r_cnt   <= '0;
        r_deb   <= 1'b1;
        r_press <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[k]};
        r_press <= 1'b0;
        if (r_sync[1] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_last) begin
          r_cnt   <= '0;
          r_deb   <= r_sync[1];
          r_press <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_deb[k]   = r_deb;
    assign w_press[k] = r_press;
  end

  // Repeat counter measures from the press event, then restarts per period.
  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_active;
  logic          r_rep;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_cnt    <= '0;
      r_rep_active <= 1'b0;
      r_rep        <= 1'b0;
    end else begin
      r_rep <= 1'b0;
      if (w_press[1]) begin
        r_rep_cnt    <= RW'(1);
        r_rep_active <= 1'b0;
      end else if (w_deb[1]) begin
        r_rep_cnt    <= '0;
        r_rep_active <= 1'b0;
      end else if (r_rep_cnt == (r_rep_active ? c_per_last : c_dly_last)) begin
        r_rep        <= 1'b1;
        r_rep_cnt    <= '0;
        r_rep_active <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOUR = 3'd1,
    S_MIN  = 3'd2,
    S_SEC  = 3'd3,
    S_LOAD = 3'd4
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_to_cnt;
  logic [4:0]    r_set_hour;
  logic [5:0]    r_set_min;
  logic [5:0]    r_set_sec;
  logic          r_load_req;
  logic          r_editing;
  logic [1:0]    r_edit_field;
  logic          w_mode;
  logic          w_inc;

  assign w_mode = w_press[0];
  assign w_inc  = w_press[1] | r_rep;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_to_cnt     <= '0;
      r_set_hour   <= '0;
      r_set_min    <= '0;
      r_set_sec    <= '0;
      r_load_req   <= 1'b0;
      r_editing    <= 1'b0;
      r_edit_field <= 2'd0;
    end else begin
      r_to_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_set_hour   <= bus.curHour;
            r_set_min    <= bus.curMin;
            r_set_sec    <= bus.curSec;
            r_state      <= S_HOUR;
            r_editing    <= 1'b1;
            r_edit_field <= 2'd1;
          end
        end
        S_HOUR, S_MIN, S_SEC: begin
          if (w_mode) begin
            // Mode wins over a coincident inc, which is simply dropped.
            case (r_state)
              S_HOUR: begin
                r_state      <= S_MIN;
                r_edit_field <= 2'd2;
              end
              S_MIN: begin
                r_state      <= S_SEC;
                r_edit_field <= 2'd3;
              end
              default: begin
                r_state      <= S_LOAD;
                r_editing    <= 1'b0;
                r_edit_field <= 2'd0;
                r_load_req   <= 1'b1;
              end
            endcase
          end else if (w_inc) begin
            case (r_state)
              S_HOUR:  r_set_hour <= (r_set_hour == 5'd23) ? 5'd0 : r_set_hour + 5'd1;
              S_MIN:   r_set_min  <= (r_set_min == 6'd59) ? 6'd0 : r_set_min + 6'd1;
              default: r_set_sec  <= (r_set_sec == 6'd59) ? 6'd0 : r_set_sec + 6'd1;
            endcase
          end else if (r_to_cnt == c_to_last) begin
            r_state      <= S_IDLE;
            r_editing    <= 1'b0;
            r_edit_field <= 2'd0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.loadAck) begin
            r_state    <= S_IDLE;
            r_load_req <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_req   <= 1'b0;
          r_editing    <= 1'b0;
          r_edit_field <= 2'd0;
        end
      endcase
    end
  end

  assign bus.setHour   = r_set_hour;
  assign bus.setMin    = r_set_min;
  assign bus.setSec    = r_set_sec;
  assign bus.loadReq   = r_load_req;
  assign bus.editing   = r_editing;
  assign bus.editField = r_edit_field;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// =============================================================================
// tb_time_set_ctrl
// Directed vector table plus hand sequences for time_set_ctrl.
// Revision: 1.0
// =============================================================================
module tb_time_set_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .CLK_HZ          (50_000_000),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .TIMEOUT         (200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit mode;
    bit inc;
    bit ack;
    int ch, cm, cs;
    int f, req, h, m, s;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int f, input int req,
                           input int h, input int m, input int s);
    check({name, ".editField"}, 32'(bus.editField), 32'(f));
    check({name, ".editing"},   32'(bus.editing),   32'(f != 0));
    check({name, ".loadReq"},   32'(bus.loadReq),   32'(req));
    check({name, ".setHour"},   32'(bus.setHour),   32'(h));
    check({name, ".setMin"},    32'(bus.setMin),    32'(m));
    check({name, ".setSec"},    32'(bus.setSec),    32'(s));
  endtask

  task automatic press(input bit m, input bit i, input int n);
    @(negedge clk);
    bus.keyModeN = ~m;
    bus.keyIncN  = ~i;
    repeat (n) @(negedge clk);
    bus.keyModeN = 1'b1;
    bus.keyIncN  = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.loadAck = 1'b1;
    @(negedge clk);
    bus.loadAck = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.curHour = 5'(h);
    bus.curMin  = 6'(m);
    bus.curSec  = 6'(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_req;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.keyModeN = 1'b1;
    bus.keyIncN  = 1'b1;
    bus.loadAck  = 1'b0;
    set_cur(12, 34, 56);

    //            mode inc ack  cur         f req  h  m  s
    vecs.push_back('{1, 0, 0, 12, 34, 56,  1, 0, 12, 34, 56});
    vecs.push_back('{0, 1, 0, 12, 34, 56,  1, 0, 13, 34, 56});
    vecs.push_back('{1, 0, 0, 12, 34, 56,  2, 0, 13, 34, 56});
    vecs.push_back('{0, 1, 0, 12, 34, 56,  2, 0, 13, 35, 56});
    vecs.push_back('{1, 0, 0, 12, 34, 56,  3, 0, 13, 35, 56});
    vecs.push_back('{0, 1, 0, 12, 34, 56,  3, 0, 13, 35, 57});
    vecs.push_back('{1, 0, 0, 12, 34, 56,  0, 1, 13, 35, 57});
    vecs.push_back('{0, 1, 0, 12, 34, 56,  0, 1, 13, 35, 57});
    vecs.push_back('{1, 0, 0, 12, 34, 56,  0, 1, 13, 35, 57});
    vecs.push_back('{0, 0, 1, 12, 34, 56,  0, 0, 13, 35, 57});
    vecs.push_back('{0, 0, 1, 12, 34, 56,  0, 0, 13, 35, 57});
    vecs.push_back('{0, 1, 0, 23, 59, 59,  0, 0, 13, 35, 57});
    vecs.push_back('{1, 0, 0, 23, 59, 59,  1, 0, 23, 59, 59});
    vecs.push_back('{0, 1, 0, 23, 59, 59,  1, 0,  0, 59, 59});
    vecs.push_back('{1, 0, 0, 23, 59, 59,  2, 0,  0, 59, 59});
    vecs.push_back('{0, 1, 0, 23, 59, 59,  2, 0,  0,  0, 59});
    vecs.push_back('{1, 0, 0, 23, 59, 59,  3, 0,  0,  0, 59});
    vecs.push_back('{0, 1, 0, 23, 59, 59,  3, 0,  0,  0,  0});
    vecs.push_back('{1, 0, 0, 23, 59, 59,  0, 1,  0,  0,  0});
    vecs.push_back('{0, 0, 1, 23, 59, 59,  0, 0,  0,  0,  0});
    vecs.push_back('{1, 0, 0,  5,  6,  7,  1, 0,  5,  6,  7});
    vecs.push_back('{1, 1, 0,  5,  6,  7,  2, 0,  5,  6,  7});
    vecs.push_back('{1, 0, 0,  5,  6,  7,  3, 0,  5,  6,  7});
    vecs.push_back('{1, 0, 0,  5,  6,  7,  0, 1,  5,  6,  7});

    repeat (3) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // A 3-cycle low glitch never reaches the debounce threshold.
    bus.keyModeN = 1'b0;
    repeat (3) @(negedge clk);
    bus.keyModeN = 1'b1;
    repeat (12) @(negedge clk);
    check_all("glitch", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      set_cur(vecs[i].ch, vecs[i].cm, vecs[i].cs);
      if (vecs[i].ack) pulse_ack();
      else press(vecs[i].mode, vecs[i].inc, 10);
      check_all($sformatf("vec%0d", i), vecs[i].f, vecs[i].req, vecs[i].h, vecs[i].m, vecs[i].s);
    end

    // LOAD holds request and values without an ack, despite cur changes.
    set_cur(9, 9, 9);
    begin
      int bad = 0;
      repeat (30) begin
        @(negedge clk);
        if (bus.loadReq !== 1'b1 || bus.setHour !== 5'd5 || bus.setMin !== 6'd6 ||
            bus.setSec !== 6'd7) bad++;
      end
      check("load_hold_bad_cycles", 32'(bad), 32'd0);
    end
    pulse_ack();
    check_all("load_ack", 0, 0, 5, 6, 7);

    // Auto-repeat: one press plus six repeats in EDIT_MIN from 10.
    set_cur(1, 10, 0);
    press(1, 0, 10);
    press(1, 0, 10);
    check_all("rep_start", 2, 0, 1, 10, 0);
    @(negedge clk);
    bus.keyIncN = 1'b0;
    repeat (46) @(negedge clk);
    bus.keyIncN = 1'b1;
    repeat (20) @(negedge clk);
    check_all("auto_repeat", 2, 0, 1, 17, 0);

    // Timeout in EDIT_SEC returns to IDLE without ever requesting a load.
    press(1, 0, 10);
    seen_req = 1'b0;
    repeat (180) begin
      @(negedge clk);
      if (bus.loadReq) seen_req = 1'b1;
    end
    check("timeout_before.editField", 32'(bus.editField), 32'd3);
    repeat (10) begin
      @(negedge clk);
      if (bus.loadReq) seen_req = 1'b1;
    end
    check_all("timeout", 0, 0, 1, 17, 0);
    check("timeout_no_req", 32'(seen_req), 32'd0);

    // Reset while in LOAD clears everything on the next cycle.
    set_cur(2, 3, 4);
    repeat (4) press(1, 0, 10);
    check_all("pre_reset_load", 0, 1, 2, 3, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all("reset_in_load", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
